// File: rtl/sync_fifo_75x512_pkg.sv
// sync_fifo_75x512_pkg: shared FIFO geometry and payload word field offsets
package sync_fifo_75x512_pkg;
  localparam int FIFO_W     = 75;
  localparam int FIFO_DEPTH = 512;
  localparam int FIFO_AW    = 9;
  localparam int VALID      = 74;
  localparam int FIRST      = 73;
  localparam int KEEP_HI    = 72;
  localparam int KEEP_LO    = 65;
  localparam int LAST       = 64;
  localparam int DATA_HI    = 63;
  localparam int DATA_LO    = 0;
endpackage

// File: rtl/sync_fifo_75x512_mem.sv
// fifo_mem_75x512: dual-port array, synchronous write, asynchronous read
module fifo_mem_75x512
  import sync_fifo_75x512_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [FIFO_AW-1:0] waddr_i,
  input  logic [FIFO_W-1:0]  wdata_i,
  input  logic [FIFO_AW-1:0] raddr_i,
  output logic [FIFO_W-1:0]  rdata_o
);
  logic [FIFO_W-1:0] mem_q [FIFO_DEPTH];
  // storage is never cleared; reset only moves the pointers
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_75x512.sv
// sync_fifo_75x512: 75x512 single-clock FWFT FIFO with registered flags
module sync_fifo_75x512
  import sync_fifo_75x512_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic [FIFO_W-1:0]  din,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [FIFO_W-1:0]  dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW-1:0] data_count
);
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, full_d, empty_q, empty_d;
  logic               wr_ok, rd_ok;
  // accept handshakes against the registered flags, then derive next pointers, count and flags
  always_comb begin
    wr_ok    = wr_en && !full_q;
    rd_ok    = rd_en && !empty_q;
    wr_ptr_d = wr_ok ? wr_ptr_q + 9'd1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 9'd1 : rd_ptr_q;
    count_d  = (wr_ok && !rd_ok) ? count_q + 10'd1 :
               (rd_ok && !wr_ok) ? count_q - 10'd1 : count_q;
    full_d   = count_d == 10'(FIFO_DEPTH);
    empty_d  = count_d == 10'd0;
  end
  // pointer, occupancy and flag registers; reset discards contents at once
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end
  fifo_mem_75x512 u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (dout)
  );
  assign full       = full_q;
  assign empty      = empty_q;
  assign data_count = count_q[FIFO_AW-1:0];
endmodule

// File: tb/tb_sync_fifo_75x512.sv
// tb_sync_fifo_75x512: scoreboard bench for the 75x512 FWFT FIFO
module tb_sync_fifo_75x512;
  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic [74:0] din = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [74:0] dout;
  logic        full, empty;
  logic [8:0]  data_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_count = 0;
  logic [74:0] sb [$];

  sync_fifo_75x512 dut (
    .clk        (clk),
    .srst       (srst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  function automatic logic [74:0] rnd75();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[74:0];
  endfunction

  // drive one cycle of stimulus and advance the reference model; no checks here
  task automatic step(input logic w, input logic r, input logic [74:0] d);
    bit wa, ra;
    wa = w && (m_count < 512);
    ra = r && (m_count > 0);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (ra) void'(sb.pop_front());
    if (wa) sb.push_back(d);
    m_count = m_count + (wa ? 1 : 0) - (ra ? 1 : 0);
  endtask

  task automatic test_reset();
    #2 srst = 1'b1;
    #2;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (data_count !== 9'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", data_count); end
    @(negedge clk) srst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    m_count = 0;
  endtask

  task automatic test_basic();
    wr_en = 1'b1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL basic_nobypass empty got=%b exp=1", empty); end
    step(1'b1, 1'b0, 75'h1);
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL basic_empty_drop got=%b exp=0", empty); end
    n_cmp++; if (dout !== 75'h1) begin n_bad++; $display("FAIL basic_first_dout got=%h exp=1", dout); end
    step(1'b1, 1'b0, 75'h2);
    step(1'b1, 1'b0, 75'h3);
    n_cmp++; if (data_count !== 9'd3) begin n_bad++; $display("FAIL basic_count got=%0d exp=3", data_count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL basic_pop%0d got=%h exp=%h", i, dout, sb[0]); end
      step(1'b0, 1'b1, '0);
    end
    n_cmp++; if (empty !== 1'b1 || data_count !== 9'd0) begin n_bad++; $display("FAIL basic_drained empty=%b count=%0d exp 1/0", empty, data_count); end
    step(1'b0, 1'b1, '0);
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || data_count !== 9'd0) begin n_bad++; $display("FAIL basic_underflow empty=%b full=%b count=%0d exp 1/0/0", empty, full, data_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 75'(i));
    n_cmp++; if (full !== 1'b1 || empty !== 1'b0 || data_count !== 9'd0) begin n_bad++; $display("FAIL fill_full full=%b empty=%b count=%0d exp 1/0/0", full, empty, data_count); end
    step(1'b1, 1'b0, 75'h3E7);
    n_cmp++; if (full !== 1'b1 || data_count !== 9'd0) begin n_bad++; $display("FAIL fill_overflow full=%b count=%0d exp 1/0", full, data_count); end
    for (int i = 0; i < 512; i++) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL fill_drain%0d got=%h exp=%h", i, dout, sb[0]); end
      step(1'b0, 1'b1, '0);
    end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL fill_empty empty=%b full=%b exp 1/0", empty, full); end
  endtask

  task automatic test_simul();
    logic [74:0] d;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 75'(10 + i));
    n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL simul5_head got=%h exp=%h", dout, sb[0]); end
    step(1'b1, 1'b1, 75'h64);
    n_cmp++; if (data_count !== 9'd5 || empty !== 1'b0) begin n_bad++; $display("FAIL simul5_count got=%0d exp=5", data_count); end
    while (m_count > 0) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL simul5_drain got=%h exp=%h", dout, sb[0]); end
      step(1'b0, 1'b1, '0);
    end
    d = rnd75();
    step(1'b1, 1'b1, d);
    n_cmp++; if (data_count !== 9'd1 || empty !== 1'b0) begin n_bad++; $display("FAIL simul0_count got=%0d exp=1", data_count); end
    n_cmp++; if (dout !== d) begin n_bad++; $display("FAIL simul0_dout got=%h exp=%h", dout, d); end
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, rnd75());
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL simul512_full got=%b exp=1", full); end
    step(1'b1, 1'b1, 75'h7AAAA);
    n_cmp++; if (data_count !== 9'd511 || full !== 1'b0) begin n_bad++; $display("FAIL simul512_count got=%0d full=%b exp 511/0", data_count, full); end
    while (m_count > 0) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL simul512_drain got=%h exp=%h", dout, sb[0]); end
      step(1'b0, 1'b1, '0);
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL simul512_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    int writes = 0;
    int guard = 0;
    step(1'b1, 1'b0, rnd75());
    writes = 1;
    while (writes < 600 && guard < 5000) begin
      logic w, r;
      guard++;
      w = (m_count < 100) && ($urandom_range(0, 1) == 1);
      r = (m_count >= 2) && ($urandom_range(0, 1) == 1);
      if (r) begin
        n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL wrap_dout got=%h exp=%h", dout, sb[0]); end
      end
      step(w, r, rnd75());
      if (w) writes++;
      n_cmp++; if (empty !== 1'b0 || full !== 1'b0 || data_count !== 9'(m_count)) begin n_bad++; $display("FAIL wrap_flags empty=%b full=%b count=%0d exp 0/0/%0d", empty, full, data_count, m_count); end
    end
    n_cmp++; if (writes < 600) begin n_bad++; $display("FAIL wrap_budget writes=%0d exp=600", writes); end
    while (m_count > 0) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL wrap_drain got=%h exp=%h", dout, sb[0]); end
      step(1'b0, 1'b1, '0);
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_async_reset();
    logic [74:0] d;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, rnd75());
    n_cmp++; if (data_count !== 9'd10) begin n_bad++; $display("FAIL areset_pre got=%0d exp=10", data_count); end
    #3 srst = 1'b1;
    #1;
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || data_count !== 9'd0) begin n_bad++; $display("FAIL areset_now empty=%b full=%b count=%0d exp 1/0/0", empty, full, data_count); end
    @(negedge clk) srst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    m_count = 0;
    d = rnd75();
    step(1'b1, 1'b0, d);
    n_cmp++; if (empty !== 1'b0 || dout !== d || data_count !== 9'd1) begin n_bad++; $display("FAIL areset_write dout=%h count=%0d exp %h/1", dout, data_count, d); end
    step(1'b0, 1'b1, '0);
    n_cmp++; if (empty !== 1'b1 || data_count !== 9'd0) begin n_bad++; $display("FAIL areset_read empty=%b count=%0d exp 1/0", empty, data_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_simul();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
